// File: rtl/line_xfer_pkg.sv
// line_xfer_pkg: sequencer state encoding and the line/offset word-address helper.
package line_xfer_pkg;
    typedef enum logic [2:0] {IDLE, WB, RD, DRAIN, DONE} state_e;
    function automatic logic [31:0] word_addr(input logic [31:0] line, input logic [31:0] off, input int ow);
        return (line << ow) | off;
    endfunction
endpackage

// File: rtl/line_word_cnt.sv
// line_word_cnt: wrapping word-offset counter with synchronous clear and last-word flag.
module line_word_cnt #(
    parameter int OW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [OW-1:0] cnt,
    output logic          last
);
    logic [OW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc ? cnt_q + OW'(1) : cnt_q);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign cnt  = cnt_q;
    assign last = &cnt_q;
endmodule

// File: rtl/line_xfer_seq.sv
// line_xfer_seq: writes back a dirty line, then refills a line through the controller fetch port.
module line_xfer_seq
    import line_xfer_pkg::*;
#(
    parameter  int mem_depth  = 32,
    parameter  int data_width = 32,
    parameter  int line_words = 4,
    localparam int AW = $clog2(mem_depth),
    localparam int OW = $clog2(line_words),
    localparam int LW = AW - OW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wb,
    input  logic [LW-1:0]         req_wb_line,
    input  logic [LW-1:0]         req_fill_line,
    output logic [OW-1:0]         wb_word_idx,
    input  logic [data_width-1:0] wb_data,
    output logic                  fill_valid,
    output logic [OW-1:0]         fill_word_idx,
    output logic [data_width-1:0] fill_data,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         fetch_mem_raddr,
    output logic                  fetch_mem_ren,
    input  logic                  fetch_mem_rready,
    input  logic [data_width-1:0] fetch_mem_rdata,
    input  logic                  fetch_mem_rdata_valid,
    output logic [AW-1:0]         fetch_mem_waddr,
    output logic                  fetch_mem_wen,
    input  logic                  fetch_mem_wready,
    output logic [data_width-1:0] fetch_mem_wdata
);
    state_e        state_q, state_d;
    logic [LW-1:0] wb_line_q, wb_line_d, fill_line_q, fill_line_d;
    logic [OW-1:0] wcnt, rcnt, vcnt;
    logic          w_last, r_last, v_last, w_inc, r_inc, v_inc, cnt_clr;

    assign busy    = state_q != IDLE;
    assign cnt_clr = state_q == IDLE;
    assign w_inc   = state_q == WB && fetch_mem_wready;
    assign r_inc   = state_q == RD && fetch_mem_rready;
    assign v_inc   = busy && fetch_mem_rdata_valid;

    line_word_cnt #(.OW(OW)) u_wcnt (.clk, .rst_n, .clr(cnt_clr), .inc(w_inc), .cnt(wcnt), .last(w_last));
    line_word_cnt #(.OW(OW)) u_rcnt (.clk, .rst_n, .clr(cnt_clr), .inc(r_inc), .cnt(rcnt), .last(r_last));
    line_word_cnt #(.OW(OW)) u_vcnt (.clk, .rst_n, .clr(cnt_clr), .inc(v_inc), .cnt(vcnt), .last(v_last));

    always_comb begin
        state_d         = state_q;
        wb_line_d       = wb_line_q;
        fill_line_d     = fill_line_q;
        req_ready       = 1'b0;
        done            = 1'b0;
        wb_word_idx     = '0;
        fetch_mem_wen   = 1'b0;
        fetch_mem_waddr = '0;
        fetch_mem_wdata = '0;
        fetch_mem_ren   = 1'b0;
        fetch_mem_raddr = '0;
        fill_valid      = v_inc;
        fill_data       = busy ? fetch_mem_rdata : '0;
        fill_word_idx   = busy ? vcnt : '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wb_line_d   = req_wb_line;
                    fill_line_d = req_fill_line;
                    state_d     = req_wb ? WB : RD;
                end
            end
            WB: begin
                fetch_mem_wen   = 1'b1;
                fetch_mem_waddr = AW'(word_addr(32'(wb_line_q), 32'(wcnt), OW));
                fetch_mem_wdata = wb_data;
                wb_word_idx     = wcnt;
                state_d         = (w_inc && w_last) ? RD : WB;
            end
            RD: begin
                fetch_mem_ren   = 1'b1;
                fetch_mem_raddr = AW'(word_addr(32'(fill_line_q), 32'(rcnt), OW));
                state_d         = (r_inc && r_last) ? DRAIN : RD;
            end
            DRAIN: state_d = (v_inc && v_last) ? DONE : DRAIN;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            wb_line_q   <= '0;
            fill_line_q <= '0;
        end else begin
            state_q     <= state_d;
            wb_line_q   <= wb_line_d;
            fill_line_q <= fill_line_d;
        end
endmodule

// File: doc/line_xfer_seq.md
Name: line_xfer_seq

Overview:
- Cache-line transfer sequencer that drives the fetch port of the on-chip memory controller.
- On a miss request it optionally writes back a dirty line word by word, then reads the refill line word by word and streams the returned words to the cache.
- Sits between the cache miss logic and the controller's fetch_mem_* read/write ports. Those ports already have priority over the cache's direct port.

Parameters:
- mem_depth, 32, number of words in the backing memory.
- data_width, 32, word width.
- line_words, 4, words per cache line; power of two, 2..mem_depth.
- Derived widths: AW = $clog2(mem_depth), OW = $clog2(line_words), LW = AW-OW.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  miss request
- req_ready  out  1  sequencer idle, request accepted on valid&&ready
- req_wb  in  1  write back dirty line before refill
- req_wb_line  in  LW  line index to write back
- req_fill_line  in  LW  line index to refill
- wb_word_idx  out  OW  word index the cache must present on wb_data (same cycle)
- wb_data  in  data_width  writeback word
- fill_valid  out  1  refill word valid
- fill_word_idx  out  OW  refill word index
- fill_data  out  data_width  refill word
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- fetch_mem_raddr  out  AW  read address
- fetch_mem_ren  out  1  read request
- fetch_mem_rready  in  1  read accepted
- fetch_mem_rdata  in  data_width  read data
- fetch_mem_rdata_valid  in  1  read data valid (one cycle after read handshake)
- fetch_mem_waddr  out  AW  write address
- fetch_mem_wen  out  1  write request
- fetch_mem_wready  in  1  write accepted
- fetch_mem_wdata  out  data_width  write data

Behaviour:
- States:
  - IDLE, WB, RD, DRAIN, DONE.
  - Reset enters IDLE and clears all counters and latched line indices.
- Reset values of outputs:
  - req_ready=1; all other outputs 0.
  - busy, done, fill_valid, fetch_mem_ren and fetch_mem_wen are 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch wb_line, fill_line and wb flag.
  - Next state is WB if req_wb, else RD. wcnt=rcnt=vcnt=0.
- WB:
  - fetch_mem_wen=1, waddr={wb_line,wcnt}, wdata=wb_data, wb_word_idx=wcnt.
  - wcnt increments on wen&&wready.
  - Handshake at wcnt==line_words-1 moves to RD.
  - Address and data are held stable while wready=0.
- RD:
  - fetch_mem_ren=1, raddr={fill_line,rcnt}.
  - rcnt increments on ren&&rready.
  - Last handshake moves to DRAIN.
- Return path:
  - In any non-IDLE state, fill_valid=fetch_mem_rdata_valid, fill_data=fetch_mem_rdata, fill_word_idx=vcnt.
  - vcnt increments on each valid word.
- DRAIN:
  - No requests issued.
  - Returned word at vcnt==line_words-1 moves to DONE.
- DONE:
  - done=1 for exactly one cycle, req_ready=0, then IDLE.
- Other outputs:
  - busy = state != IDLE.
  - wb_word_idx = 0 outside WB.
- Latency with ports always ready:
  - Fill only: done asserts line_words+2 cycles after the accept cycle.
  - With writeback: 2*line_words+2 cycles.
- Same line for writeback and refill is legal. Writes complete before the first read issues, so refill returns the written data.
- Counters are OW bits and wrap naturally. Index arithmetic is a concatenation, with no carry into the line field.
- Back-to-back requests: the next request can only be accepted in the IDLE cycle after DONE.
- Ignored inputs:
  - rdata_valid in IDLE.
  - Stray valid beyond line_words in DRAIN or DONE.
- Reset asserted mid-operation:
  - Immediately forces IDLE and all outputs to reset values.
  - No partial done is produced; the partial line is abandoned.

Decomposition:
- Package line_xfer_pkg holds:
  - the state enum (IDLE, WB, RD, DRAIN, DONE);
  - a function building word address from (line, offset) for given LW/OW.
- One natural sub-module, line_word_cnt: parameterised OW-bit counter with inc, clear and last flag. It is instantiated three times (wcnt, rcnt, vcnt).

Test Plan:
- Fill only: mem[8..11]=A0..A3, req fill_line=2, req_wb=0. Response:
  - ren addresses 8,9,10,11 on four consecutive cycles;
  - fill_valid with idx0..3 and data A0..A3;
  - done at accept+6, req_ready back to 1 the next cycle.
- Writeback plus fill: wb_line=5, fill_line=1, wb_data=0xD0+wb_word_idx. Response:
  - wen addresses 20..23 with data D0..D3;
  - then reads of 4..7;
  - done at accept+10.
- Same line: wb_line=fill_line=3 with data D0..D3. Response: fill_data sequence D0,D1,D2,D3.
- Backpressure:
  - wready=0 for 2 cycles at word1: waddr=21 and wdata=D1 held, no word skipped or duplicated.
  - rready=0 for 3 cycles at word2: raddr held, idx order preserved.
- Reset mid-WB after word1: all enables drop asynchronously, busy=0, req_ready=1, no done. A new fill request then completes normally.
- Back-to-back with req_valid held high: second accept occurs in the IDLE cycle after DONE; req_ready=0 throughout busy and DONE.
